// File: rtl/spi_slave_rx_pkg.sv
// Shared SPI link settings and receive-side state encoding.
// The master imports the same mode constants so both ends agree on framing.
package spi_slave_rx_pkg;

    localparam int   SPI_DATA_W    = 8;
    localparam logic SPI_CPOL      = 1'b0;
    localparam logic SPI_CPHA      = 1'b0;
    localparam logic SPI_MSB_FIRST = 1'b1;

    // Cycles the synchroniser needs before its output reflects the pins.
    localparam logic [1:0] SYNC_FLUSH_CYCLES = 2'd2;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } rx_state_t;

endpackage

// File: rtl/spi_slave_rx_sync_2ff.sv
// Two-flop synchroniser for a bundle of asynchronous inputs.
// Each bit is treated independently; there is no bus coherency guarantee.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI receive endpoint: oversamples SCK/CS/MOSI, deserialises words and
// presents them on a valid/ready holding register with error flags.
//
//   state     | meaning
//   WAIT_IDLE | after reset, wait for CS high so we never join mid-word
//   IDLE      | CS high, bit counter cleared
//   SHIFT     | CS low, shifting MOSI on each sampling SCK edge
module spi_slave_rx
    import spi_slave_rx_pkg::*;
#(
    parameter int   DATA_W    = SPI_DATA_W,
    parameter logic CPOL      = SPI_CPOL,
    parameter logic CPHA      = SPI_CPHA,
    parameter logic MSB_FIRST = SPI_MSB_FIRST
) (
    input  logic              clk_100,
    input  logic              s_rst,
    input  logic              sck,
    input  logic              cs_n,
    input  logic              mosi,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);

    generate
        if (DATA_W < 2) begin : g_bad_width
            $error("spi_slave_rx: DATA_W must be at least 2");
        end
    endgenerate

    logic [2:0]        w_sync;
    logic              w_sck;
    logic              w_cs_n;
    logic              w_mosi;
    logic              w_sck_edge;
    logic              w_sample;
    logic              w_shift_en;
    logic              w_word_done;
    logic              w_frame_abort;
    logic              w_frame_end;
    logic [DATA_W-1:0] w_shift_nxt;
    rx_state_t         w_state_nxt;

    rx_state_t         r_state;
    logic              r_sck_d;
    logic [1:0]        r_flush;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_frame_err;
    logic              r_overrun;

    sync_2ff #(
        .WIDTH   (3),
        .RST_VAL ({CPOL, 1'b1, 1'b0})
    ) u_sync (
        .i_clk (clk_100),
        .i_rst (s_rst),
        .i_d   ({sck, cs_n, mosi}),
        .o_q   (w_sync)
    );

    assign w_sck  = w_sync[2];
    assign w_cs_n = w_sync[1];
    assign w_mosi = w_sync[0];

    // Leading edge moves away from the idle level, trailing edge returns to it.
    assign w_sck_edge = (w_sck != r_sck_d);
    assign w_sample   = CPHA ? (w_sck_edge && (w_sck == CPOL))
                             : (w_sck_edge && (w_sck != CPOL));

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_en    = 1'b0;
        w_frame_abort = 1'b0;
        case (r_state)
            // The synchroniser still shows its reset value (CS high) for a
            // couple of cycles, so wait for it to flush before trusting CS.
            WAIT_IDLE: begin
                if ((r_flush == 2'd0) && w_cs_n)
                    w_state_nxt = IDLE;
            end
            IDLE: begin
                if (!w_cs_n)
                    w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (w_cs_n) begin
                    w_state_nxt   = IDLE;
                    w_frame_abort = (r_bit_cnt != '0);
                end else if (w_sample) begin
                    w_shift_en = 1'b1;
                end
            end
            default: w_state_nxt = WAIT_IDLE;
        endcase
    end

    always_comb begin
        if (MSB_FIRST)
            w_shift_nxt = {r_shift[DATA_W-2:0], w_mosi};
        else
            w_shift_nxt = {w_mosi, r_shift[DATA_W-1:1]};
    end

    assign w_frame_end = (r_state == SHIFT) && w_cs_n;
    assign w_word_done = w_shift_en && (r_bit_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            r_state     <= WAIT_IDLE;
            r_sck_d     <= CPOL;
            r_flush     <= SYNC_FLUSH_CYCLES;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sck_d     <= w_sck;
            r_frame_err <= w_frame_abort;

            if (r_flush != 2'd0)
                r_flush <= r_flush - 2'd1;

            if (w_frame_end) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else if (w_shift_en) begin
                r_shift   <= w_shift_nxt;
                r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + CNT_W'(1);
            end

            // A completing word only replaces the held one if it is leaving now.
            if (w_word_done) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data  <= w_shift_nxt;
                    r_rx_valid <= 1'b1;
                end
            end else if (rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            if (w_word_done && r_rx_valid && !rx_ready)
                r_overrun <= 1'b1;
            else if (ovr_clr)
                r_overrun <= 1'b0;
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state == SHIFT);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench: two receivers (mode 0 MSB-first, mode 3 LSB-first) share
// CS/MOSI; a bit-stream model predicts words, a monitor checks each transfer.
module tb_spi_slave_rx;

    localparam int DW = 8;

    logic          clk_100;
    logic          s_rst;
    logic          sck_a;
    logic          sck_b;
    logic          cs_n;
    logic          mosi;
    logic          rx_ready;
    logic          ovr_clr;
    logic [DW-1:0] a_data;
    logic          a_valid;
    logic          a_ferr;
    logic          a_ovr;
    logic          a_busy;
    logic [DW-1:0] b_data;
    logic          b_valid;
    logic          b_ferr;
    logic          b_ovr;
    logic          b_busy;

    spi_slave_rx #(.DATA_W(DW), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_dut_a (
        .clk_100 (clk_100), .s_rst (s_rst), .sck (sck_a), .cs_n (cs_n), .mosi (mosi),
        .rx_data (a_data), .rx_valid (a_valid), .rx_ready (rx_ready),
        .frame_err (a_ferr), .overrun (a_ovr), .ovr_clr (ovr_clr), .busy (a_busy)
    );

    spi_slave_rx #(.DATA_W(DW), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) u_dut_b (
        .clk_100 (clk_100), .s_rst (s_rst), .sck (sck_b), .cs_n (cs_n), .mosi (mosi),
        .rx_data (b_data), .rx_valid (b_valid), .rx_ready (rx_ready),
        .frame_err (b_ferr), .overrun (b_ovr), .ovr_clr (ovr_clr), .busy (b_busy)
    );

    initial begin
        clk_100 = 1'b0;
        forever #5 clk_100 = ~clk_100;
    end

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_a[$];
    logic [DW-1:0] exp_b[$];
    logic          cur_bits[$];
    bit            model_rec = 1'b1;
    int            exp_ferr  = 0;
    int            ferr_a    = 0;
    int            ferr_b    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word value from the received bit order: first bit weighs most (MSB-first) or least.
    function automatic logic [DW-1:0] assemble(input bit msb_first);
        int v = 0;
        for (int i = 0; i < DW; i++)
            if (cur_bits[i])
                v += msb_first ? (1 << (DW - 1 - i)) : (1 << i);
        return DW'(v);
    endfunction

    task automatic model_bit(input logic b);
        if (model_rec) begin
            cur_bits.push_back(b);
            if (cur_bits.size() == DW) begin
                exp_a.push_back(assemble(1'b1));
                exp_b.push_back(assemble(1'b0));
                cur_bits.delete();
            end
        end
    endtask

    task automatic model_frame_end();
        if (model_rec && cur_bits.size() != 0)
            exp_ferr++;
        cur_bits.delete();
    endtask

    always @(negedge clk_100) begin
        if (!s_rst) begin
            if (a_valid && rx_ready) begin
                if (exp_a.size() == 0) check("unexpected_word_a", 32'(a_data), 32'hFFFF_FFFF);
                else check("word_a", 32'(a_data), 32'(exp_a.pop_front()));
            end
            if (b_valid && rx_ready) begin
                if (exp_b.size() == 0) check("unexpected_word_b", 32'(b_data), 32'hFFFF_FFFF);
                else check("word_b", 32'(b_data), 32'(exp_b.pop_front()));
            end
            if (a_ferr) ferr_a++;
            if (b_ferr) ferr_b++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100);
        #1;
    endtask

    // mode 0: plain bit; 1: raise rx_ready to meet this word's completion;
    // 2: check the rx_valid latency relative to the sampling edge.
    task automatic send_bit(input logic b, input int mode);
        sck_b = 1'b0;
        mosi  = b;
        tick(4);
        sck_a = 1'b1;
        sck_b = 1'b1;
        model_bit(b);
        case (mode)
            1: begin
                tick(2);
                rx_ready = 1'b1;
                tick(1);
                check("same_cycle_valid_a", 32'(a_valid), 32'd1);
                check("same_cycle_data_a", 32'(a_data), 32'(exp_a[$]));
                check("same_cycle_data_b", 32'(b_data), 32'(exp_b[$]));
                check("same_cycle_ovr_a", 32'(a_ovr), 32'd0);
                tick(1);
            end
            2: begin
                tick(2);
                check("latency_early_a", 32'(a_valid), 32'd0);
                check("latency_early_b", 32'(b_valid), 32'd0);
                tick(1);
                check("latency_edge_a", 32'(a_valid), 32'd1);
                check("latency_edge_b", 32'(b_valid), 32'd1);
                tick(1);
            end
            default: tick(4);
        endcase
        sck_a = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int last_mode);
        logic [DW-1:0] v;
        v = w;
        for (int i = DW - 1; i >= 0; i--)
            send_bit(v[i], (i == 0) ? last_mode : 0);
    endtask

    task automatic cs_lo();
        cs_n = 1'b0;
        tick(4);
    endtask

    task automatic cs_hi();
        cs_n = 1'b1;
        model_frame_end();
        tick(6);
    endtask

    initial begin
        int cnt_a;
        int cnt_b;
        int t;
        logic [DW-1:0] w1;

        sck_a = 1'b0; sck_b = 1'b1; cs_n = 1'b1; mosi = 1'b0;
        rx_ready = 1'b1; ovr_clr = 1'b0; s_rst = 1'b1;
        tick(3);
        s_rst = 1'b0;
        check("rst_valid_a", 32'(a_valid), 32'd0);
        check("rst_data_a", 32'(a_data), 32'd0);
        check("rst_ferr_a", 32'(a_ferr), 32'd0);
        check("rst_ovr_a", 32'(a_ovr), 32'd0);
        check("rst_busy_a", 32'(a_busy), 32'd0);
        check("rst_valid_b", 32'(b_valid), 32'd0);
        tick(4);

        // Single word with latency check
        cs_lo();
        check("busy_a", 32'(a_busy), 32'd1);
        check("busy_b", 32'(b_busy), 32'd1);
        send_word(8'hA5, 2);
        cs_hi();
        check("ovr_after_a5", 32'(a_ovr), 32'd0);

        // Overrun: second word dropped while first is held
        rx_ready = 1'b0;
        cs_lo();
        send_word(8'h3C, 0);
        model_rec = 1'b0;
        send_word(8'hC3, 0);
        model_rec = 1'b1;
        cs_hi();
        check("held_valid_a", 32'(a_valid), 32'd1);
        check("held_data_a", 32'(a_data), 32'h3C);
        check("held_data_b", 32'(b_data), 32'h3C);
        check("ovr_set_a", 32'(a_ovr), 32'd1);
        check("ovr_set_b", 32'(b_ovr), 32'd1);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        check("ovr_clr_a", 32'(a_ovr), 32'd0);
        check("ovr_clr_b", 32'(b_ovr), 32'd0);
        rx_ready = 1'b1;
        tick(3);

        // Framing error on 5-bit frame
        cs_lo();
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 0);
        cs_n = 1'b1;
        model_frame_end();
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (a_ferr) cnt_a++;
            if (b_ferr) cnt_b++;
        end
        check("ferr_width_a", 32'(cnt_a), 32'd1);
        check("ferr_width_b", 32'(cnt_b), 32'd1);
        check("ferr_no_valid_a", 32'(a_valid), 32'd0);
        cs_lo();
        send_word(8'h81, 0);
        cs_hi();

        // First bit set, others clear: 80 MSB-first, 01 LSB-first
        cs_lo();
        send_word(8'h80, 0);
        cs_hi();

        // Reset mid-frame, keep clocking with CS low
        cs_lo();
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 0);
        s_rst = 1'b1;
        tick(1);
        s_rst = 1'b0;
        cur_bits.delete();
        model_rec = 1'b0;
        for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)), 0);
        check("post_rst_valid_a", 32'(a_valid), 32'd0);
        check("post_rst_valid_b", 32'(b_valid), 32'd0);
        check("post_rst_busy_a", 32'(a_busy), 32'd0);
        cs_hi();
        model_rec = 1'b1;
        cs_lo();
        send_word(8'h5A, 0);
        cs_hi();

        // Completion coincides with consumption of the held word
        rx_ready = 1'b0;
        w1 = DW'($urandom_range(0, 255));
        cs_lo();
        send_word(w1, 0);
        send_word(DW'($urandom_range(0, 255)), 1);
        cs_hi();
        rx_ready = 1'b1;

        // Random frames: 1-3 words, sometimes a trailing partial word
        for (int f = 0; f < 20; f++) begin
            cs_lo();
            for (int w = 0; w < int'($urandom_range(1, 3)); w++)
                send_word(DW'($urandom_range(0, 255)), 0);
            if ($urandom_range(0, 3) == 0)
                for (int k = 0; k < int'($urandom_range(1, DW - 1)); k++)
                    send_bit(1'($urandom_range(0, 1)), 0);
            cs_hi();
            tick($urandom_range(0, 5));
        end

        t = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && t < 100) begin
            tick(1);
            t++;
        end
        check("pending_words_a", 32'(exp_a.size()), 32'd0);
        check("pending_words_b", 32'(exp_b.size()), 32'd0);
        check("ferr_count_a", 32'(ferr_a), 32'(exp_ferr));
        check("ferr_count_b", 32'(ferr_b), 32'(exp_ferr));
        check("final_ovr_a", 32'(a_ovr), 32'd0);
        check("final_ovr_b", 32'(b_ovr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI receive endpoint: the far end of the SPI master link.
- Oversamples the external SCK/CS/MOSI lines in the clk_100 domain and deserialises MOSI into DATA_W-bit words.
- Presents each word on a valid/ready handshake and flags framing errors and overruns.
- Used as a loopback/checker target for the master and as the receive half of a future full-duplex core.

Parameters:
- DATA_W, 8: bits per word.
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- MSB_FIRST, 1: 1 = first received bit lands in rx_data[DATA_W-1], 0 = lands in rx_data[0].

Ports:
- clk_100  in  1  system clock, 100 MHz.
- s_rst  in  1  reset, synchronous, active-high.
- sck  in  1  SPI clock from master, asynchronous to clk_100.
- cs_n  in  1  chip select, active-low, asynchronous.
- mosi  in  1  serial data from master, asynchronous.
- rx_data  out  DATA_W  received word, stable while rx_valid=1.
- rx_valid  out  1  word available.
- rx_ready  in  1  consumer accepts the word; transfer occurs when rx_valid and rx_ready are both high.
- frame_err  out  1  one-cycle pulse: CS deasserted mid-word.
- overrun  out  1  sticky: a word completed while the holding register was full.
- ovr_clr  in  1  clears overrun.
- busy  out  1  high in SHIFT state.

Behaviour:
- Interface decision: one clock (clk_100); reset s_rst is synchronous and active-high.
- Synchronisation:
  - sck, cs_n and mosi each pass through a 2-FF synchroniser.
  - A registered copy of synced sck is kept for edge detection.
- Timing constraint: SCK high and low phases each must be >= 3 clk_100 periods. No behaviour is guaranteed for faster SCK.
- Sample edge:
  - Leading edge = synced sck transitions away from CPOL; trailing edge = transitions back to CPOL.
  - Sample on leading edge when CPHA=0, on trailing edge when CPHA=1.
  - Non-sampling edges are ignored.
- Latency:
  - A sample edge detected in cycle N shifts synced mosi into the shift register in cycle N.
  - On the DATA_W-th sample, rx_data/rx_valid update at the end of cycle N.
  - Result: rx_valid rises 3 clk_100 edges after the sampling SCK pin edge.
- State machine:
  - WAIT_IDLE (reset state): wait for synced cs_n=1, then go to IDLE. This prevents joining a frame mid-word after reset.
  - IDLE: bit_cnt=0. Synced cs_n=0 -> SHIFT.
  - SHIFT:
    - Each sample edge increments bit_cnt.
    - At bit_cnt = DATA_W-1 plus a sample edge: word complete, bit_cnt wraps to 0, remain in SHIFT (back-to-back words under one CS are supported).
    - Synced cs_n=1 with bit_cnt != 0: pulse frame_err, discard the partial word, go to IDLE.
    - Synced cs_n=1 with bit_cnt = 0: go to IDLE, no error.
  - A sample edge coincident with the cs_n rise is ignored; the cs_n check has priority.
- Holding register / handshake:
  - Word complete with rx_valid=0: load rx_data, set rx_valid.
  - Word complete with rx_valid=1 and rx_ready=1 in the same cycle: load the new word, rx_valid stays 1, no overrun.
  - Word complete with rx_valid=1 and rx_ready=0: keep the old word, drop the new one, set overrun.
  - rx_ready=1 with rx_valid=1 and no completion: clear rx_valid. rx_data holds its last value.
  - rx_ready while rx_valid=0 is ignored.
  - overrun: cleared by ovr_clr. If set and clear occur in the same cycle, set wins.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, bit_cnt=0, shift register=0, state=WAIT_IDLE. Synchroniser flops reset to sck=CPOL, cs_n=1, mosi=0.
- s_rst asserted mid-frame: all state is cleared and the partial word is lost with no frame_err. The block then waits in WAIT_IDLE for CS high.
- bit_cnt width: $clog2(DATA_W). Assertion: DATA_W >= 2.

Decomposition:
- config_pkg additions: rx_state_t enum (WAIT_IDLE, IDLE, SHIFT); SPI_DATA_W, SPI_CPOL and SPI_CPHA constants shared with the master so both ends agree on mode.
- One sub-module: sync_2ff (parameterised width, reset value), instantiated once for the 3-bit {sck, cs_n, mosi} bundle.
- Edge detect, FSM, shift register and holding register stay in spi_slave_rx.

Test Plan:
- Mode 0, SCK period 80 ns, cs_n low, send 8'hA5 MSB first, rx_ready=1 -> one rx_valid pulse with rx_data=8'hA5, 3 clk_100 edges after the 8th rising SCK; frame_err=0, overrun=0.
- Back-to-back 8'h3C, 8'hC3 under one CS, rx_ready held 0 -> rx_data=8'h3C stays; overrun=1 after the second word. Then ovr_clr pulse -> overrun=0.
- Send 5 bits then raise cs_n -> frame_err high exactly 1 cycle, rx_valid stays 0. Next full frame 8'h81 -> rx_data=8'h81.
- CPOL=1, CPHA=1, MSB_FIRST=0, send bit sequence 1,0,0,0,0,0,0,0 -> rx_data=8'h01.
- Assert s_rst for 1 cycle after 4 bits while cs_n stays low; continue clocking 12 more bits; raise CS; then send 8'h5A in a new frame -> no rx_valid before the new frame, then rx_data=8'h5A; frame_err never pulses.
- Word completion in the same cycle as an rx_ready consume of the previous word -> rx_valid stays 1, rx_data switches to the new word, overrun=0.
